// File: rtl/range_enqueuer.sv
`default_nettype none
// ============================================================================
// Module      : range_enqueuer
// Description : Reads a small header block once over AXI (numV and a per-task
//               enqueue limit), then for each continuation task splits the
//               index range [start, end) into child tasks and, when work
//               remains, re-enqueues a continuation starting at end.
//               Optional feature macro: RANGE_ENQ_STATS_EN adds a saturating
//               count of enqueued tasks on port stat_enq_count.
// Revision    : 1.0 - initial release
// ============================================================================
module range_enqueuer #(
  parameter int LIMIT_W      = 7,
  parameter int HDR_LAST_IDX = 9,
  parameter int NUMV_IDX     = 1,
  parameter int LIMIT_IDX    = 9,
  parameter int CONT_TTYPE   = 0,
  parameter int CHILD_TTYPE  = 1,
  parameter int TS_INC       = 0,
  parameter int OBJ_SHIFT    = 4,
  parameter int TS_W         = 32,
  parameter int OBJ_W        = 32,
  parameter int TTYPE_W      = 4,
  // Task word layout {args[31:0], ttype, object, ts}; keep derived.
  parameter int TQ_WIDTH     = 32 + TTYPE_W + OBJ_W + TS_W
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  input  logic [TQ_WIDTH-1:0] task_in,
  output logic [TQ_WIDTH-1:0] task_out_V_TDATA,
  output logic                task_out_V_TVALID,
  input  logic                task_out_V_TREADY,
  output logic                m_axi_l1_V_ARVALID,
  output logic [31:0]         m_axi_l1_V_ARADDR,
  output logic [7:0]          m_axi_l1_V_ARLEN,
  output logic [2:0]          m_axi_l1_V_ARSIZE,
  input  logic                m_axi_l1_V_ARREADY,
  input  logic                m_axi_l1_V_RVALID,
  input  logic [31:0]         m_axi_l1_V_RDATA,
  input  logic                m_axi_l1_V_RLAST,
  output logic                m_axi_l1_V_RREADY,
  output logic [31:0]         ap_state
`ifdef RANGE_ENQ_STATS_EN
  ,
  output logic [31:0]         stat_enq_count
`endif
);

  localparam int ARGS_LSB = TS_W + OBJ_W + TTYPE_W;
  localparam int TT_LSB   = TS_W + OBJ_W;
  localparam logic [7:0]         NUMV_B  = 8'(NUMV_IDX);
  localparam logic [7:0]         LIMIT_B = 8'(LIMIT_IDX);
  localparam logic [TTYPE_W-1:0] CONT_T  = TTYPE_W'(CONT_TTYPE);
  localparam logic [TTYPE_W-1:0] CHILD_T = TTYPE_W'(CHILD_TTYPE);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ_HDR  = 3'd1,
    S_WAIT_HDR  = 3'd2,
    S_DISPATCH  = 3'd3,
    S_ENQ_CONT  = 3'd4,
    S_ENQ_CHILD = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t               state;
  logic                 initialized;
  logic [7:0]           beat_cnt;
  logic [31:0]          num_v;
  logic [LIMIT_W-1:0]   limit_q;
  logic [31:0]          start_q;
  logic [TTYPE_W-1:0]   ttype_q;
  logic [TS_W-1:0]      ts_q;
  logic [31:0]          cursor;

  // The incoming object field is replaced in every emitted task.
  logic unused_obj;
  assign unused_obj = ^task_in[TS_W +: OBJ_W];

  function automatic logic [TQ_WIDTH-1:0] pack_task(
    input logic [31:0]        args,
    input logic [TTYPE_W-1:0] ttype,
    input logic [OBJ_W-1:0]   obj,
    input logic [TS_W-1:0]    ts
  );
    return {args, ttype, obj, ts};
  endfunction

  // Range end = min(start + max(limit,1), numV), in 33 bits so it never wraps.
  logic [LIMIT_W-1:0] lim_eff;
  logic [32:0]        range_sum;
  logic [31:0]        end_w;
  logic               cont_needed;
  logic [31:0]        cursor_nxt;
  logic [OBJ_W-1:0]   cont_obj;
  logic [TS_W-1:0]    child_ts;

  assign lim_eff     = (limit_q == '0) ? LIMIT_W'(1) : limit_q;
  assign range_sum   = {1'b0, start_q} + 33'(lim_eff);
  assign end_w       = (range_sum < {1'b0, num_v}) ? range_sum[31:0] : num_v;
  assign cont_needed = (end_w < num_v);
  assign cursor_nxt  = cursor + 32'd1;
  assign cont_obj    = OBJ_W'(start_q) << OBJ_SHIFT;
  assign child_ts    = ts_q + TS_W'(TS_INC);

  assign m_axi_l1_V_ARADDR = 32'd0;
  assign m_axi_l1_V_ARLEN  = 8'(HDR_LAST_IDX);
  assign m_axi_l1_V_ARSIZE = 3'b010;
  assign ap_idle           = (state == S_IDLE);
  assign ap_ready          = (state == S_IDLE);
  assign ap_state          = {29'd0, state};

  // Control FSM: header fetch, continuation then child enqueue, done pulse.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state              <= S_IDLE;
      initialized        <= 1'b0;
      beat_cnt           <= 8'd0;
      cursor             <= 32'd0;
      num_v              <= 32'd0;
      limit_q            <= '0;
      start_q            <= 32'd0;
      ttype_q            <= '0;
      ts_q               <= '0;
      task_out_V_TVALID  <= 1'b0;
      task_out_V_TDATA   <= '0;
      m_axi_l1_V_ARVALID <= 1'b0;
      m_axi_l1_V_RREADY  <= 1'b0;
      ap_done            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            start_q <= task_in[ARGS_LSB +: 32];
            ttype_q <= task_in[TT_LSB +: TTYPE_W];
            ts_q    <= task_in[TS_W-1:0];
            if (initialized) begin
              state <= S_DISPATCH;
            end else begin
              m_axi_l1_V_ARVALID <= 1'b1;
              state              <= S_READ_HDR;
            end
          end
        end
        S_READ_HDR: begin
          if (m_axi_l1_V_ARREADY) begin
            m_axi_l1_V_ARVALID <= 1'b0;
            m_axi_l1_V_RREADY  <= 1'b1;
            beat_cnt           <= 8'd0;
            state              <= S_WAIT_HDR;
          end
        end
        S_WAIT_HDR: begin
          if (m_axi_l1_V_RVALID) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt == NUMV_B)  num_v   <= m_axi_l1_V_RDATA;
            if (beat_cnt == LIMIT_B) limit_q <= m_axi_l1_V_RDATA[LIMIT_W-1:0];
            if (m_axi_l1_V_RLAST) begin
              m_axi_l1_V_RREADY <= 1'b0;
              initialized       <= 1'b1;
              state             <= S_DISPATCH;
            end
          end
        end
        S_DISPATCH: begin
          cursor <= start_q;
          if (ttype_q == CONT_T) begin
            state <= S_ENQ_CONT;
            if (cont_needed) begin
              task_out_V_TVALID <= 1'b1;
              task_out_V_TDATA  <= pack_task(end_w, CONT_T, cont_obj, ts_q);
            end
          end else begin
            ap_done <= 1'b1;
            state   <= S_FINISH;
          end
        end
        S_ENQ_CONT: begin
          // Leave once the continuation (if any) is accepted; preload child 0.
          if (!task_out_V_TVALID || task_out_V_TREADY) begin
            state <= S_ENQ_CHILD;
            if (cursor < end_w) begin
              task_out_V_TVALID <= 1'b1;
              task_out_V_TDATA  <= pack_task(32'd0, CHILD_T, OBJ_W'(cursor), child_ts);
            end else begin
              task_out_V_TVALID <= 1'b0;
            end
          end
        end
        S_ENQ_CHILD: begin
          if (!task_out_V_TVALID) begin
            ap_done <= 1'b1;
            state   <= S_FINISH;
          end else if (task_out_V_TREADY) begin
            cursor <= cursor_nxt;
            if (cursor_nxt < end_w) begin
              task_out_V_TDATA <= pack_task(32'd0, CHILD_T, OBJ_W'(cursor_nxt), child_ts);
            end else begin
              task_out_V_TVALID <= 1'b0;
              ap_done           <= 1'b1;
              state             <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          ap_done <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RANGE_ENQ_STATS_EN
  // Saturating count of accepted output tasks.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stat_enq_count <= 32'd0;
    end else if (task_out_V_TVALID && task_out_V_TREADY && (stat_enq_count != 32'hFFFF_FFFF)) begin
      stat_enq_count <= stat_enq_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_range_enqueuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_range_enqueuer
// Description : Directed bench for range_enqueuer with an AXI header slave
//               model and an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_range_enqueuer;
  localparam int TQ     = 100;
  localparam int TS_INC = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready;
  logic [TQ-1:0] task_in = '0;
  logic [TQ-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b1;
  logic          arvalid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic          arready = 1'b0;
  logic          rvalid = 1'b0;
  logic [31:0]   rdata = 32'd0;
  logic          rlast = 1'b0;
  logic          rready;
  logic [31:0]   ap_state;
`ifdef RANGE_ENQ_STATS_EN
  logic [31:0]   stat_enq_count;
`endif

  range_enqueuer #(.TS_INC(TS_INC)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .task_in(task_in),
    .task_out_V_TDATA(tdata), .task_out_V_TVALID(tvalid), .task_out_V_TREADY(tready),
    .m_axi_l1_V_ARVALID(arvalid), .m_axi_l1_V_ARADDR(araddr),
    .m_axi_l1_V_ARLEN(arlen), .m_axi_l1_V_ARSIZE(arsize),
    .m_axi_l1_V_ARREADY(arready),
    .m_axi_l1_V_RVALID(rvalid), .m_axi_l1_V_RDATA(rdata), .m_axi_l1_V_RLAST(rlast),
    .m_axi_l1_V_RREADY(rready),
    .ap_state(ap_state)
`ifdef RANGE_ENQ_STATS_EN
    , .stat_enq_count(stat_enq_count)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int passed = 0;
  int total  = 0;
  int hs_count = 0;
  int done_cnt = 0;
  int done_base = 0;
  int ar_count = 0;
  logic [TQ-1:0] exp_q[$];
  logic [31:0]   hdr[0:9];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [TQ-1:0] mk(input logic [31:0] a, input logic [3:0] t,
                                       input logic [31:0] o, input logic [31:0] s);
    return {a, t, o, s};
  endfunction

  // Output monitor: scoreboard pops, stall stability, done pulse count.
  initial begin : monitor
    logic          pv;
    logic          pr;
    logic [TQ-1:0] pd;
    pv = 1'b0; pr = 1'b1; pd = '0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin
        pv = 1'b0;
      end else begin
        if (ap_done) done_cnt++;
        if (pv && !pr) begin
          check("stall_valid", 128'(tvalid), 128'(1));
          check("stall_data", 128'(tdata), 128'(pd));
        end
        if (tvalid && tready) begin
          hs_count++;
          check("queue_nonempty", 128'(exp_q.size() != 0), 128'(1));
          if (exp_q.size() != 0) check("task_data", 128'(tdata), 128'(exp_q.pop_front()));
        end
        pv = tvalid; pr = tready; pd = tdata;
      end
    end
  end

  // AXI read slave returning hdr[] as one burst per AR handshake.
  initial begin : axi_slave
    logic arv, arr, rv, rr, rl;
    int   beat;
    logic busy;
    beat = 0; busy = 1'b0;
    forever begin
      @(negedge ap_clk);
      arv = arvalid; arr = arready; rv = rvalid; rr = rready; rl = rlast;
      if (arv && arr && !ap_rst) begin
        ar_count++;
        check("araddr", 128'(araddr), 128'(0));
        check("arlen", 128'(arlen), 128'(9));
        check("arsize", 128'(arsize), 128'(2));
      end
      @(posedge ap_clk); #1;
      if (ap_rst) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; busy = 1'b0; beat = 0;
      end else if (arv && arr) begin
        arready = 1'b0; busy = 1'b1; beat = 0;
        rvalid = 1'b1; rdata = hdr[0]; rlast = 1'b0;
      end else if (arv) begin
        arready = 1'b1;
      end else if (busy && rv && rr) begin
        if (rl) begin
          busy = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        end else begin
          beat++;
          rdata = hdr[beat];
          rlast = (beat == 9);
        end
      end
    end
  end

  task automatic start_task(input logic [3:0] tt, input logic [31:0] args, input logic [31:0] ts);
    @(posedge ap_clk); #1;
    done_base = done_cnt;
    task_in   = mk(args, tt, 32'hDEAD_BEEF, ts);
    ap_start  = 1'b1;
    @(posedge ap_clk); #1;
    ap_start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!ap_idle && n < 500);
    check({tag, "_idle"}, 128'(ap_idle), 128'(1));
    check({tag, "_done_pulses"}, 128'(done_cnt - done_base), 128'(1));
    check({tag, "_sb_empty"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin : stim
    int n;
    int hb;
    int arb;
    for (int i = 0; i < 10; i++) hdr[i] = 32'hC0DE_0000 + i;
    hdr[1] = 32'd20;
    hdr[9] = 32'h5A5A_0008;   // limit field (7 bits) = 8

    // Reset state
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_idle", 128'(ap_idle), 128'(1));
    check("rst_ready", 128'(ap_ready), 128'(1));
    check("rst_done", 128'(ap_done), 128'(0));
    check("rst_tvalid", 128'(tvalid), 128'(0));
    check("rst_arvalid", 128'(arvalid), 128'(0));
    check("rst_rready", 128'(rready), 128'(0));
    check("rst_state", 128'(ap_state), 128'(0));
`ifdef RANGE_ENQ_STATS_EN
    check("rst_stat", 128'(stat_enq_count), 128'(0));
`endif
    ap_rst = 1'b0;

    // First task: header read, continuation args=8, children 0..7
    exp_q.push_back(mk(32'd8, 4'd0, 32'd0, 32'h100));
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'd0, 4'd1, i, 32'h100 + TS_INC));
    start_task(4'd0, 32'd0, 32'h100);
    wait_idle("t1");
    check("t1_ar_count", 128'(ar_count), 128'(1));

    // args=2: continuation object 2<<4, children 2..9 with a 3-cycle stall
    exp_q.push_back(mk(32'd10, 4'd0, 32'd32, 32'h200));
    for (int i = 2; i < 10; i++) exp_q.push_back(mk(32'd0, 4'd1, i, 32'h200 + TS_INC));
    hb = hs_count;
    start_task(4'd0, 32'd2, 32'h200);
    n = 0;
    while (hs_count < hb + 4 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    check("t2_reach_stall", 128'(hs_count >= hb + 4), 128'(1));
    @(posedge ap_clk); #1;
    tready = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    tready = 1'b1;
    wait_idle("t2");

    // args=16: end clipped to numV, no continuation, no header re-read
    for (int i = 16; i < 20; i++) exp_q.push_back(mk(32'd0, 4'd1, i, 32'h300 + TS_INC));
    start_task(4'd0, 32'd16, 32'h300);
    wait_idle("t3");
    check("t3_ar_count", 128'(ar_count), 128'(1));

    // Non-continuation task: nothing emitted
    hb = hs_count;
    start_task(4'd1, 32'd3, 32'h400);
    wait_idle("t4");
    check("t4_no_emit", 128'(hs_count - hb), 128'(0));

    // New headers: numV=6, limit=0; reset so they get re-read
    hdr[1] = 32'd6;
    hdr[9] = 32'hFFFF_FF80;
    @(negedge ap_clk);
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // Reset while waiting for header data
    arb = ar_count;
    start_task(4'd0, 32'd5, 32'h500);
    n = 0;
    while (ap_state != 32'd2 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check("t5_reach_wait_hdr", 128'(ap_state), 128'(2));
    ap_rst = 1'b1;
    #1;
    check("t5_rst_state", 128'(ap_state), 128'(0));
    check("t5_rst_idle", 128'(ap_idle), 128'(1));
    check("t5_rst_rready", 128'(rready), 128'(0));
`ifdef RANGE_ENQ_STATS_EN
    check("t5_rst_stat", 128'(stat_enq_count), 128'(0));
`endif
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    check("t5_ar_first", 128'(ar_count - arb), 128'(1));

    // limit=0 -> 1: end=6=numV, no continuation, child 5 only, header re-read
    hb = hs_count;
    exp_q.push_back(mk(32'd0, 4'd1, 32'd5, 32'h600 + TS_INC));
    start_task(4'd0, 32'd5, 32'h600);
    wait_idle("t6");
    check("t6_ar_reissued", 128'(ar_count - arb), 128'(2));
    check("t6_emit_count", 128'(hs_count - hb), 128'(1));

    // start >= numV: nothing emitted
    hb = hs_count;
    start_task(4'd0, 32'd7, 32'h700);
    wait_idle("t7");
    check("t7_no_emit", 128'(hs_count - hb), 128'(0));
`ifdef RANGE_ENQ_STATS_EN
    check("stat_count", 128'(stat_enq_count), 128'(hs_count - hb + 1));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/range_enqueuer.md
RANGE_ENQUEUER -- requirements
Module: range_enqueuer

Interface
REQ-001 SHALL have parameter LIMIT_W, default 7: width of the per-task enqueue limit field read from the header.
REQ-002 SHALL have parameter HDR_LAST_IDX, default 9: index of the last header word; read burst ARLEN = HDR_LAST_IDX.
REQ-003 SHALL have parameter NUMV_IDX, default 1, and LIMIT_IDX, default 9: header word indices of numV and the limit.
REQ-004 SHALL have parameter CONT_TTYPE, default 0, and CHILD_TTYPE, default 1: continuation and child task types.
REQ-005 SHALL have parameter TS_INC, default 0: amount added to the parent ts to form the child ts.
REQ-006 SHALL have parameter OBJ_SHIFT, default 4: left shift applied to the start index to form the continuation object.
REQ-007 SHALL have ports:
 ap_clk  in  1  sole clock
 ap_rst  in  1  asynchronous, active-high reset
 ap_start  in  1  task offered
 ap_done / ap_idle / ap_ready  out  1 each  handshake status
 task_in  in  TQ_WIDTH  {args, ttype, object, ts}
 task_out_V_TDATA  out  TQ_WIDTH  enqueued task
 task_out_V_TVALID  out  1;  task_out_V_TREADY  in  1
 m_axi_l1_V_ARVALID/ARADDR/ARLEN/ARSIZE  out  1/32/8/3
 m_axi_l1_V_ARREADY  in  1
 m_axi_l1_V_RVALID/RDATA/RLAST  in  1/32/1;  m_axi_l1_V_RREADY  out  1
 ap_state  out  32  current state encoding
REQ-008 SHALL use one clock (ap_clk); reset ap_rst SHALL be asynchronous and active-high.

Function
REQ-009 SHALL implement states IDLE, READ_HDR, WAIT_HDR, DISPATCH, ENQ_CONT, ENQ_CHILD, FINISH.
REQ-010 IDLE & ap_start: SHALL latch task_in; go to DISPATCH if initialized, else READ_HDR.
REQ-011 READ_HDR: SHALL assert ARVALID, ARADDR=0, ARLEN=HDR_LAST_IDX, ARSIZE=3'b010; on ARREADY go to WAIT_HDR.
REQ-012 RREADY SHALL be high only in WAIT_HDR; a beat counter SHALL reset on the AR handshake and increment per R beat; numV and the limit SHALL capture at their indices; on RVALID & RLAST go to DISPATCH and set initialized.
REQ-013 DISPATCH: ttype == CONT_TTYPE -> ENQ_CONT; any other ttype -> FINISH, emitting nothing.
REQ-014 start = args[31:0]; lim = limit, with 0 treated as 1; end = min(start + lim, numV), computed in 33 bits so no wrap-around.
REQ-015 ENQ_CONT: if end < numV, SHALL emit {ttype=CONT_TTYPE, object=start<<OBJ_SHIFT, args=end, ts=parent ts}; advance on TREADY. Otherwise advance without emitting.
REQ-016 ENQ_CHILD: a cursor SHALL load start in DISPATCH; while cursor < end, SHALL emit {ttype=CHILD_TTYPE, object=cursor, args=0, ts=parent ts+TS_INC}; cursor SHALL increment per handshake (one task per cycle at full throughput); at cursor >= end go to FINISH.
REQ-017 If start >= numV: no tasks SHALL be emitted, DISPATCH -> ENQ_CONT -> ENQ_CHILD -> FINISH.
REQ-018 Once TVALID is asserted, TVALID and TDATA SHALL hold stable until TREADY.
REQ-019 ap_done SHALL be high for exactly the one FINISH cycle; ap_idle = ap_ready = (state == IDLE).

Reset
REQ-020 ap_rst SHALL immediately force: state=IDLE, initialized=0, beat counter=0, cursor=0, TVALID=0, ARVALID=0, RREADY=0, ap_done=0, ap_idle=ap_ready=1.
REQ-021 Reset mid-burst or mid-enqueue SHALL abandon the task; the next task SHALL re-read headers.

Configuration
REQ-022 With RANGE_ENQ_STATS_EN defined: SHALL add output stat_enq_count (32 bits), reset to 0, incremented on each TVALID & TREADY, saturating at all-ones.
REQ-023 Without RANGE_ENQ_STATS_EN: the port and counter SHALL be absent; behaviour is otherwise identical.

Verification
REQ-024 First task {ttype=0, args=0}, numV=20, limit=8 -> one header burst ARLEN=9; continuation args=8, object=0; children 0..7, ts unchanged+TS_INC.
REQ-025 Second task {ttype=0, args=16}, numV=20, limit=8 -> no header read, no continuation; children 16..19; done.
REQ-026 TREADY low 3 cycles mid-child stream -> TDATA stable while stalled; no index skipped or duplicated.
REQ-027 Task ttype=1 -> DISPATCH->FINISH, zero tasks emitted, ap_done pulses once.
REQ-028 limit=0, args=5, numV=6 -> continuation args=6 not emitted (end=numV); child 5 only.
REQ-029 ap_rst asserted in WAIT_HDR -> IDLE same cycle; next task re-issues AR burst; with RANGE_ENQ_STATS_EN, stat_enq_count=0 after reset.
